// File: rtl/seg7_readback_if.sv
// -----------------------------------------------------------------------------
// seg7_readback_if
// Bundle of the scanned display bus being monitored and the decoded status
// that the readback block returns.
//
//   seg_in      : segment lines, active low, bit6=g .. bit0=a
//   an_in       : digit enables, active low, one digit low when valid
//   digits_out  : decoded hex, digit i at [4i+3:4i]
//   blank_out   : digit i last committed the blank pattern
//   bad_out     : digit i last committed an illegal pattern
//   frame_valid : one-cycle pulse, every digit committed since last pulse
//   anode_err   : one-cycle pulse, stable sample with zero or >=2 anodes low
//
// master : the side driving the display bus (display driver / testbench)
// slave  : the readback decoder
// -----------------------------------------------------------------------------
interface seg7_readback_if #(
  parameter int NUM_DIGITS = 4
);

  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [NUM_DIGITS-1:0]   blank_out;
  logic [NUM_DIGITS-1:0]   bad_out;
  logic                    frame_valid;
  logic                    anode_err;

  modport master (
    output seg_in,
    output an_in,
    input  digits_out,
    input  blank_out,
    input  bad_out,
    input  frame_valid,
    input  anode_err
  );

  modport slave (
    input  seg_in,
    input  an_in,
    output digits_out,
    output blank_out,
    output bad_out,
    output frame_valid,
    output anode_err
  );

endinterface

// File: rtl/seg7_readback.sv
// -----------------------------------------------------------------------------
// seg7_readback
// Loopback monitor for the multiplexed active-low 7-segment display bus.
// Samples {an_in, seg_in} every clock, waits for STABLE_CYCLES identical
// samples, then decodes the segment pattern back to a hex nibble for the
// single digit whose anode is low. Blank (0x7F) and illegal patterns are
// flagged per digit; a frame pulse fires once every digit has been committed.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus_if : seg7_readback_if.slave (seg_in/an_in in, decoded status out)
//
// Parameters:
//   NUM_DIGITS    : number of scanned digits (1..8)
//   STABLE_CYCLES : identical samples required before commit (2..255)
//
// Stability FSM:
//   state    | meaning
//   ST_COUNT | sample not yet committed; counting identical samples
//   ST_HELD  | current stable sample already committed; wait for a change
// -----------------------------------------------------------------------------
module seg7_readback #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_readback_if.slave  bus_if
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [NUM_DIGITS-1:0]   r_an_q;
  logic [6:0]              r_seg_q;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;

  logic                    w_same;
  logic                    w_commit;

  logic [NUM_DIGITS-1:0]   w_an_low;
  logic                    w_one_hot;
  logic [NUM_DIGITS-1:0]   w_hit;

  logic                    w_legal;
  logic                    w_blank;
  logic [3:0]              w_hex;

  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_bad;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic                    w_seen_full;
  logic                    r_frame;
  logic                    r_anode_err;

  // ---------------------------------------------------------------------------
  // Sample register, stability counter and FSM state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_q  <= '1;
      r_seg_q <= 7'h7F;
      r_cnt   <= '0;
      r_state <= ST_COUNT;
    end else begin
      r_an_q  <= bus_if.an_in;
      r_seg_q <= bus_if.seg_in;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign w_same = ({bus_if.an_in, bus_if.seg_in} == {r_an_q, r_seg_q});

  // A commit acts on the held sample even if the bus changes on the same edge;
  // the change still rearms the FSM so the new value gets its own stable period.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;

    if (!w_same) begin
      w_cnt_nxt = CNT_ONE;
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end

    case (r_state)
      ST_COUNT: begin
        if (r_cnt == CNT_MAX) begin
          w_commit = 1'b1;
          if (w_same) begin
            w_state_nxt = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (!w_same) begin
          w_state_nxt = ST_COUNT;
        end
      end
      default: begin
        w_state_nxt = ST_COUNT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Anode qualification: exactly one enable low selects the digit
  // ---------------------------------------------------------------------------
  assign w_an_low  = ~r_an_q;
  assign w_one_hot = (w_an_low != '0) && ((w_an_low & (w_an_low - 1'b1)) == '0);
  assign w_hit     = (w_commit && w_one_hot) ? w_an_low : '0;

  // ---------------------------------------------------------------------------
  // Segment pattern decode (active-low, bit6=g .. bit0=a)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_legal = 1'b1;
    w_blank = 1'b0;
    w_hex   = 4'h0;
    case (r_seg_q)
      7'h40: w_hex = 4'h0;
      7'h79: w_hex = 4'h1;
      7'h24: w_hex = 4'h2;
      7'h30: w_hex = 4'h3;
      7'h19: w_hex = 4'h4;
      7'h12: w_hex = 4'h5;
      7'h02: w_hex = 4'h6;
      7'h78: w_hex = 4'h7;
      7'h00: w_hex = 4'h8;
      7'h10: w_hex = 4'h9;
      7'h08: w_hex = 4'hA;
      7'h03: w_hex = 4'hB;
      7'h46: w_hex = 4'hC;
      7'h21: w_hex = 4'hD;
      7'h06: w_hex = 4'hE;
      7'h7F: begin
        w_hex   = 4'hF;
        w_blank = 1'b1;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-digit status, frame tracking and error pulse
  // ---------------------------------------------------------------------------
  assign w_seen_full = &r_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits    <= '1;
      r_blank     <= '1;
      r_bad       <= '0;
      r_seen      <= '0;
      r_frame     <= 1'b0;
      r_anode_err <= 1'b0;
    end else begin
      r_anode_err <= w_commit && !w_one_hot;
      r_frame     <= w_seen_full;
      // A commit landing on the clearing edge keeps its seen bit.
      r_seen      <= (w_seen_full ? '0 : r_seen) | w_hit;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_hit[i]) begin
          if (w_legal) begin
            r_digits[4*i +: 4] <= w_hex;
            r_blank[i]         <= w_blank;
            r_bad[i]           <= 1'b0;
          end else begin
            // Illegal pattern keeps the last good nibble for this digit.
            r_blank[i]         <= 1'b0;
            r_bad[i]           <= 1'b1;
          end
        end
      end
    end
  end

  assign bus_if.digits_out  = r_digits;
  assign bus_if.blank_out   = r_blank;
  assign bus_if.bad_out     = r_bad;
  assign bus_if.frame_valid = r_frame;
  assign bus_if.anode_err   = r_anode_err;

endmodule

// File: tb/tb_seg7_readback.sv
module tb_seg7_readback;

  localparam int ND = 4;
  localparam int SC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  seg7_readback_if #(.NUM_DIGITS(ND)) bus_if ();

  seg7_readback #(
    .NUM_DIGITS   (ND),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bus_if)
  );

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  blank;
    logic [3:0]  bad;
    logic        fv;
    logic        ae;
  } exp_t;

  typedef struct {
    int         edge_no;
    logic [3:0] an;
    logic [6:0] seg;
  } pend_t;

  exp_t  sb_q[$];
  pend_t pend[$];

  int n_chk = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int fv_cnt = 0;
  int ae_cnt = 0;
  logic glitch_watch = 1'b0;
  logic glitch_zero  = 1'b0;

  logic [15:0] m_dig;
  logic [3:0]  m_blank;
  logic [3:0]  m_bad;
  logic [3:0]  m_seen;
  logic [6:0]  seg_tab [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_digits"}, 32'(bus_if.digits_out), 32'hFFFF);
    check({tag, "_blank"},  32'(bus_if.blank_out),  32'hF);
    check({tag, "_bad"},    32'(bus_if.bad_out),    32'h0);
    check({tag, "_fv"},     32'(bus_if.frame_valid), 32'h0);
    check({tag, "_ae"},     32'(bus_if.anode_err),  32'h0);
  endtask

  task automatic model_reset();
    m_dig   = 16'hFFFF;
    m_blank = 4'hF;
    m_bad   = 4'h0;
    m_seen  = 4'h0;
    pend.delete();
    sb_q.delete();
  endtask

  // Expected outputs right after the current clock edge.
  task automatic model_edge(output exp_t e);
    pend_t p;
    int    d;
    int    found;
    edge_cnt++;
    e.fv = (m_seen == 4'hF);
    e.ae = 1'b0;
    if (e.fv) m_seen = 4'h0;
    if (pend.size() != 0 && pend[0].edge_no == edge_cnt) begin
      p = pend.pop_front();
      if ($countones(~p.an) == 1) begin
        d = 0;
        for (int i = 0; i < ND; i++) if (!p.an[i]) d = i;
        found = -1;
        for (int h = 0; h < 16; h++) if (seg_tab[h] == p.seg) found = h;
        if (found >= 0) begin
          m_dig[4*d +: 4] = 4'(found);
          m_blank[d]      = (found == 15);
          m_bad[d]        = 1'b0;
        end else begin
          m_blank[d] = 1'b0;
          m_bad[d]   = 1'b1;
        end
        m_seen[d] = 1'b1;
      end else begin
        e.ae = 1'b1;
      end
    end
    e.dig   = m_dig;
    e.blank = m_blank;
    e.bad   = m_bad;
  endtask

  task automatic tick();
    exp_t e;
    exp_t o;
    @(posedge clk);
    model_edge(e);
    sb_q.push_back(e);
    @(negedge clk);
    o = {bus_if.digits_out, bus_if.blank_out, bus_if.bad_out,
         bus_if.frame_valid, bus_if.anode_err};
    fv_cnt += int'(bus_if.frame_valid);
    ae_cnt += int'(bus_if.anode_err);
    if (glitch_watch && bus_if.digits_out[7:4] == 4'h0) glitch_zero = 1'b1;
    e = sb_q.pop_front();
    check($sformatf("edge%0d", edge_cnt), 32'(o), 32'(e));
  endtask

  // Drive a pattern (always different from the previous one) for n cycles.
  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus_if.an_in  = an;
    bus_if.seg_in = seg;
    if (n >= SC) pend.push_back('{edge_cnt + 1 + SC, an, seg});
    repeat (n) tick();
  endtask

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h7F;

    bus_if.an_in  = 4'hF;
    bus_if.seg_in = 7'h7F;
    model_reset();

    #2 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single digit, then a long hold that must not re-commit
    hold(4'b1110, 7'h12, 24);
    check("d0_hex",   32'(bus_if.digits_out[3:0]), 32'h5);
    check("d0_blank", 32'(bus_if.blank_out[0]),    32'h0);
    check("d0_bad",   32'(bus_if.bad_out[0]),      32'h0);

    // Full scan
    fv_cnt = 0;
    hold(4'b1110, 7'h79, 5);
    hold(4'b1101, 7'h24, 5);
    hold(4'b1011, 7'h30, 5);
    hold(4'b0111, 7'h19, 5);
    check("scan_digits", 32'(bus_if.digits_out), 32'h4321);
    check("fv_early", 32'(fv_cnt), 32'd0);

    // Illegal pattern keeps nibble, then blank
    hold(4'b1011, 7'h7E, 6);
    check("fv_once",    32'(fv_cnt), 32'd1);
    check("bad2",       32'(bus_if.bad_out[2]), 32'h1);
    check("bad2_nib",   32'(bus_if.digits_out[11:8]), 32'h3);
    check("bad2_blank", 32'(bus_if.blank_out[2]), 32'h0);
    hold(4'b1011, 7'h7F, 5);
    check("blank2",     32'(bus_if.blank_out[2]), 32'h1);
    check("blank2_nib", 32'(bus_if.digits_out[11:8]), 32'hF);
    check("blank2_bad", 32'(bus_if.bad_out[2]), 32'h0);

    // Anode errors: two low, none low
    ae_cnt = 0;
    hold(4'b1100, 7'h12, 5);
    check("ae_two_low", 32'(ae_cnt), 32'd1);
    hold(4'b1111, 7'h40, 5);
    check("ae_none_low", 32'(ae_cnt), 32'd2);
    check("ae_nochange", 32'(bus_if.digits_out), 32'h4F21);

    // Glitch rejection: 0x40 for 3 cycles never commits
    glitch_watch = 1'b1;
    hold(4'b1101, 7'h40, 3);
    hold(4'b1101, 7'h79, 4);
    hold(4'b1110, 7'h12, 6);
    glitch_watch = 1'b0;
    check("glitch_zero", 32'(glitch_zero), 32'h0);
    check("glitch_d1",   32'(bus_if.digits_out[7:4]), 32'h1);

    // Reset mid-scan clears everything, next frame needs all digits
    hold(4'b1110, 7'h40, 5);
    hold(4'b1101, 7'h79, 5);
    rst_n = 1'b0;
    #1 check_reset("mid");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fv_cnt = 0;
    hold(4'b0111, 7'h19, 5);
    hold(4'b1110, 7'h12, 5);
    check("post_rst_no_fv", 32'(fv_cnt), 32'd0);
    hold(4'b1101, 7'h24, 5);
    hold(4'b1011, 7'h30, 5);
    hold(4'b1110, 7'h40, 3);
    check("post_rst_fv", 32'(fv_cnt), 32'd1);
    check("post_rst_digits", 32'(bus_if.digits_out), 32'h4325);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seg7_readback.md
# seg7_readback

Readback decoder for the board's multiplexed, active-low 7-segment display bus: the inverse of the hex-to-segment encoder. It samples the scanned segment and anode lines, waits for each pattern to be stable, and decodes it back to a 4-bit hex value per digit. It also flags blank and illegal patterns, and pulses when a complete scan frame has been captured. It sits beside the display driver as a self-check/loopback monitor feeding status logic and test benches.

## Interface
- NUM_DIGITS, 4, number of scanned digits (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required before commit (2..255)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_in  in  7  segment lines, active low, bit6=g … bit0=a
- an_in  in  NUM_DIGITS  digit enables, active low, one digit low when valid
- digits_out  out  4*NUM_DIGITS  decoded hex, digit i at [4i+3:4i]
- blank_out  out  NUM_DIGITS  digit i last committed blank pattern
- bad_out  out  NUM_DIGITS  digit i last committed an illegal pattern
- frame_valid  out  1  one-cycle pulse: every digit committed since last pulse
- anode_err  out  1  one-cycle pulse: stable sample with zero or ≥2 anodes low

## Operation
- Decode table, seg_in to hex:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x06→E
  - 0x02→6, 0x78→7, 0x00→8, 0x10→9, 0x08→A, 0x03→B, 0x46→C, 0x21→D
  - 0x7F→F with blank=1
  - Any other value is illegal: bad=1, blank=0, hex for that digit unchanged.
- Sample register {an_q, seg_q} captures {an_in, seg_in} every clk.
- Stability counter cnt (width ≥ clog2(STABLE_CYCLES+1)):
  - Incoming sample equals current sample: cnt saturating-increments at STABLE_CYCLES.
  - Otherwise cnt ← 1 and done ← 0.
- Commit: when cnt == STABLE_CYCLES and done == 0, the next edge sets done ← 1 and acts on the sample:
  - Exactly one an_q bit low (digit i): write hex/blank/bad for digit i and set seen[i].
  - Otherwise: pulse anode_err and write nothing.
  - Each stable period commits at most once; re-holding the same value does not re-commit.
- Frame:
  - When seen is all ones, at the next edge pulse frame_valid and clear seen.
  - If a commit lands on the same edge as the clear, its seen bit survives the clear. No digit is lost.
- Re-committing a digit before frame completion overwrites its value; seen stays 1.

## Timing
- Reset (asynchronous, immediate):
  - digits_out all 0xF, blank_out all 1, bad_out 0, frame_valid 0, anode_err 0.
  - seen 0, cnt 0, done 0, sample = {all 1, 0x7F}.
- Latency: inputs constant from just before edge 1 give cnt == STABLE_CYCLES at edge STABLE_CYCLES. Outputs and anode_err update at edge STABLE_CYCLES+1.
- frame_valid asserts the edge after the commit that completes seen. Worst case STABLE_CYCLES+2 edges after the last digit's inputs settle.
- Glitch rejection: any sample held fewer than STABLE_CYCLES cycles is never committed. A change during counting restarts from 1.
- frame_valid and anode_err are never asserted two consecutive cycles from one event.
- Deassertion of rst_n is taken synchronously by downstream logic; the block needs no extra sequencing.

## Test plan
- Reset mid-scan (after digit 1 commits): assert rst_n=0 → immediately all outputs return to reset values and seen is cleared; next frame needs all 4 digits again.
- Hold an_in=4'b1110, seg_in=0x12 for 4 cycles → at edge 5 digits_out[3:0]=5, blank_out[0]=0, bad_out[0]=0; holding 20 more cycles produces no further commit.
- Scan digits 0..3 with 0x79, 0x24, 0x30, 0x19, each held 5 cycles → digits_out=16'h4321; one frame_valid pulse 1 edge after the digit-3 commit.
- Digit 2 with 0x7E held 6 cycles after digit 2 = 3 → bad_out[2]=1, digits_out[11:8] stays 3. Then 0x7F → blank_out[2]=1, nibble = F, bad_out[2]=0.
- an_in=4'b1100 held 4 cycles → single anode_err pulse at edge 5, no digit changes, seen unchanged. an_in=4'b1111 behaves the same.
- Pattern 0x40 on digit 1 for 3 cycles (STABLE_CYCLES=4), then 0x79 for 4 → only 1 committed; 0 never appears.
